// File: rtl/core_pkg.sv
// Shared core types and constants used by the fetch stage and its PC register.
package core_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int INST_WIDTH          = 32;
  localparam int INST_MEM_ADDR_WIDTH = 10;

  // The canonical NOP instruction: addi x0, x0, 0.
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [DATA_WIDTH-1:0] PC_ALIGN_MASK = ~32'd3;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } fetch_state_e;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } if_id_data_t;

  localparam if_id_data_t IF_ID_BUBBLE = '{inst: NOP_INST, pc: '0, pc_plus4: '0};

endpackage

// File: rtl/pc_reg.sv
// Program counter register. Load has priority over hold; otherwise it advances by 4.
module pc_reg
  import core_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_pc_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;

  assign pc_plus4_o = pc_q + DATA_WIDTH'(4);
  assign pc_o       = pc_q;

  always_comb begin
    pc_d = pc_plus4_o;
    if (load_i)      pc_d = load_pc_i;
    else if (hold_i) pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, IF/ID register and boot/run/halt control.
// Optional build macro FETCH_MISALIGN_CHK_EN halts on misaligned redirect targets.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                    IMEM_AW  = INST_MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic [IMEM_AW-1:0]    imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_rdata_i,
  output if_id_data_t           if_id_o,
  output logic                  if_id_valid_o,
`ifdef FETCH_MISALIGN_CHK_EN
  output logic                  misalign_o,
`endif
  output logic                  halted_o
);

  fetch_state_e          state_q, state_d;
  if_id_data_t           if_id_q, if_id_d;
  logic                  valid_q, valid_d;
  logic                  pc_hold, pc_load;
  logic [DATA_WIDTH-1:0] pc, pc_plus4, redirect_tgt;

  // Low target bits are dropped unconditionally; the checker only decides whether to halt.
  assign redirect_tgt = redirect_pc_i & PC_ALIGN_MASK;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (pc_hold),
    .load_i     (pc_load),
    .load_pc_i  (redirect_tgt),
    .pc_o       (pc),
    .pc_plus4_o (pc_plus4)
  );

  assign imem_addr_o   = pc[IMEM_AW+1:2];
  assign if_id_o       = if_id_q;
  assign if_id_valid_o = valid_q;
  assign halted_o      = (state_q == S_HALT);

  always_comb begin
    state_d = state_q;
    if_id_d = if_id_q;
    valid_d = valid_q;
    pc_hold = 1'b1;
    pc_load = 1'b0;
    if (state_q == S_BOOT) begin
      if_id_d = IF_ID_BUBBLE;
      valid_d = 1'b0;
      state_d = S_RUN;
    end else if (redirect_i) begin
      pc_load = 1'b1;
      if_id_d = IF_ID_BUBBLE;
      valid_d = 1'b0;
      state_d = S_RUN;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc_i[1:0] != 2'b00) state_d = S_HALT;
`endif
    end else if (state_q == S_HALT || halt_i) begin
      if_id_d = IF_ID_BUBBLE;
      valid_d = 1'b0;
      state_d = S_HALT;
    end else if (!stall_i) begin
      pc_hold = 1'b0;
      if_id_d = '{inst: imem_rdata_i, pc: pc, pc_plus4: pc_plus4};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      if_id_q <= IF_ID_BUBBLE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;

  assign misalign_o = misalign_q;

  // Sticky until reset; only redirects that are actually accepted can set it.
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else if (state_q != S_BOOT && redirect_i && redirect_pc_i[1:0] != 2'b00) misalign_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset/boot, stall, redirect, halt, wrap, misalign, reset mid-stream.
module tb_fetch_stage;
  import core_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall_i, redirect_i, halt_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic [9:0]            imem_addr_o;
  logic [INST_WIDTH-1:0] imem_rdata_i;
  if_id_data_t           if_id_o;
  logic                  if_id_valid_o, halted_o;
`ifdef FETCH_MISALIGN_CHK_EN
  logic                  misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory model: word at address a holds 0x11 + a.
  assign imem_rdata_i = 32'h11 + {22'd0, imem_addr_o};

  fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_id_o       (if_id_o),
    .if_id_valid_o (if_id_valid_o),
`ifdef FETCH_MISALIGN_CHK_EN
    .misalign_o    (misalign_o),
`endif
    .halted_o      (halted_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0; redirect_pc_i = '0;
    repeat (3) step();
    checks++;
    if ({if_id_valid_o, halted_o, if_id_o, imem_addr_o} !== {2'b00, NOP_INST, 64'h0, 10'h0}) begin
      errors++;
      $display("FAIL reset_state got v=%b h=%b ifid=%h addr=%h want v=0 h=0 ifid=%h addr=0",
               if_id_valid_o, halted_o, if_id_o, imem_addr_o, {NOP_INST, 64'h0});
    end
    rst = 1'b0;
    step();
    checks++;
    if ({if_id_valid_o, if_id_o, imem_addr_o} !== {1'b0, NOP_INST, 64'h0, 10'h0}) begin
      errors++;
      $display("FAIL boot_bubble got v=%b ifid=%h addr=%h want bubble addr=0",
               if_id_valid_o, if_id_o, imem_addr_o);
    end
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h11, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL first_fetch got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o, if_id_o,
               {32'h11, 32'h0, 32'h4});
    end
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h12, 32'h4, 32'h8}) begin
      errors++;
      $display("FAIL second_fetch got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o, if_id_o,
               {32'h12, 32'h4, 32'h8});
    end
  endtask

  task automatic test_stall();
    repeat (2) step();  // advance pc from 0x8 to 0x10
    checks++;
    if (imem_addr_o !== 10'h4) begin
      errors++;
      $display("FAIL stall_setup got addr=%h want addr=004", imem_addr_o);
    end
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if_id_valid_o, if_id_o, imem_addr_o} !== {1'b1, 32'h14, 32'hC, 32'h10, 10'h4}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b ifid=%h addr=%h want v=1 ifid=%h addr=004", i,
                 if_id_valid_o, if_id_o, imem_addr_o, {32'h14, 32'hC, 32'h10});
      end
    end
    stall_i = 1'b0;
    step();
    checks++;
    if ({if_id_valid_o, if_id_o, imem_addr_o} !== {1'b1, 32'h15, 32'h10, 32'h14, 10'h5}) begin
      errors++;
      $display("FAIL stall_release got v=%b ifid=%h addr=%h want v=1 ifid=%h addr=005",
               if_id_valid_o, if_id_o, imem_addr_o, {32'h15, 32'h10, 32'h14});
    end
  endtask

  task automatic test_redirect_stall();
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    step();
    stall_i = 1'b0; redirect_i = 1'b0;
    checks++;
    if ({if_id_valid_o, if_id_o, imem_addr_o} !== {1'b0, NOP_INST, 64'h0, 10'h40}) begin
      errors++;
      $display("FAIL redir_stall_flush got v=%b ifid=%h addr=%h want bubble addr=040",
               if_id_valid_o, if_id_o, imem_addr_o);
    end
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h51, 32'h100, 32'h104}) begin
      errors++;
      $display("FAIL redir_stall_target got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o,
               if_id_o, {32'h51, 32'h100, 32'h104});
    end
  endtask

  task automatic test_halt_resume();
    redirect_i = 1'b1; redirect_pc_i = 32'h20;
    step();
    redirect_i = 1'b0; halt_i = 1'b1;
    step();
    halt_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({halted_o, if_id_valid_o, imem_addr_o} !== {2'b10, 10'h8}) begin
        errors++;
        $display("FAIL halt_hold[%0d] got h=%b v=%b addr=%h want h=1 v=0 addr=008", i,
                 halted_o, if_id_valid_o, imem_addr_o);
      end
      step();
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    checks++;
    if ({halted_o, if_id_valid_o, imem_addr_o} !== {2'b00, 10'h10}) begin
      errors++;
      $display("FAIL halt_exit got h=%b v=%b addr=%h want h=0 v=0 addr=010", halted_o,
               if_id_valid_o, imem_addr_o);
    end
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h21, 32'h40, 32'h44}) begin
      errors++;
      $display("FAIL halt_resume_fetch got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o,
               if_id_o, {32'h21, 32'h40, 32'h44});
    end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h410, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("FAIL wrap_fetch got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o, if_id_o,
               {32'h410, 32'hFFFF_FFFC, 32'h0});
    end
    step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h11, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL wrap_next got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o, if_id_o,
               {32'h11, 32'h0, 32'h4});
    end
  endtask

  task automatic test_misalign();
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    step();
    redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    step();
    checks++;
    if ({misalign_o, halted_o, if_id_valid_o, imem_addr_o} !== {3'b110, 10'h40}) begin
      errors++;
      $display("FAIL misalign_halt got m=%b h=%b v=%b addr=%h want m=1 h=1 v=0 addr=040",
               misalign_o, halted_o, if_id_valid_o, imem_addr_o);
    end
`else
    step();
    checks++;
    if ({halted_o, if_id_valid_o, if_id_o} !== {2'b01, 32'h51, 32'h100, 32'h104}) begin
      errors++;
      $display("FAIL misalign_forced got h=%b v=%b ifid=%h want h=0 v=1 ifid=%h", halted_o,
               if_id_valid_o, if_id_o, {32'h51, 32'h100, 32'h104});
    end
`endif
  endtask

  task automatic test_reset_midstream();
    step();
    rst = 1'b1; stall_i = 1'b1; redirect_i = 1'b1; halt_i = 1'b1; redirect_pc_i = 32'h200;
    step();
    checks++;
    if ({if_id_valid_o, halted_o, if_id_o, imem_addr_o} !== {2'b00, NOP_INST, 64'h0, 10'h0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b h=%b ifid=%h addr=%h want bubble addr=000",
               if_id_valid_o, halted_o, if_id_o, imem_addr_o);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (misalign_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign got m=%b want m=0", misalign_o);
    end
`endif
    rst = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; halt_i = 1'b0;
    repeat (2) step();
    checks++;
    if ({if_id_valid_o, if_id_o} !== {1'b1, 32'h11, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL reset_mid_restart got v=%b ifid=%h want v=1 ifid=%h", if_id_valid_o,
               if_id_o, {32'h11, 32'h0, 32'h4});
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stall();
    test_halt_resume();
    test_wrap();
    test_misalign();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
